// File: rtl/dtree_walker_ctrl.sv
// dtree_walker_ctrl
// Time-multiplexed decision-tree classifier. One node of a tree held in an
// external combinational ROM is evaluated per clock with a single shared
// threshold comparator. A 4-feature sample enters through a valid/ready
// handshake, the tree is walked from ROOT_ADDR to a leaf, and the class
// label leaves through a second valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   sample handshake; X0..X3 latched on acceptance
//   X0..X3              8-bit features
//   node_addr           node ROM address
//   node_data           node word {leaf, feat[2], nb[3], thr[8], left, right}
//   out_valid/out_ready result handshake
//   out_class           class label (0 on abort)
//   out_err             walk aborted after MAX_DEPTH nodes
//   busy                high while walking or holding a result
module dtree_walker_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int CLASS_W   = 2,
    parameter int ROOT_ADDR = 0,
    parameter int MAX_DEPTH = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             X0,
    input  logic [7:0]             X1,
    input  logic [7:0]             X2,
    input  logic [7:0]             X3,
    output logic [ADDR_W-1:0]      node_addr,
    input  logic [14+2*ADDR_W-1:0] node_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLASS_W-1:0]     out_class,
    output logic                   out_err,
    output logic                   busy
);

    localparam int NODE_W  = 14 + 2*ADDR_W;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DEPTH_W-1:0]  depth, depth_n;
    logic [CLASS_W-1:0]  class_n;
    logic                err_n;
    logic [7:0]          f0, f1, f2, f3;
    logic                load;

    // Node word fields
    logic                is_leaf;
    logic [1:0]          feat;
    logic [2:0]          nb;
    logic [7:0]          thr;
    logic [ADDR_W-1:0]   left_child, right_child;

    assign is_leaf     = node_data[NODE_W-1];
    assign feat        = node_data[NODE_W-2 -: 2];
    assign nb          = node_data[NODE_W-4 -: 3];
    assign thr         = node_data[NODE_W-7 -: 8];
    assign left_child  = node_data[2*ADDR_W-1 -: ADDR_W];
    assign right_child = node_data[ADDR_W-1:0];

    // Shared comparator: keep the top nb+1 bits of the selected feature,
    // right-aligned, and compare unsigned against the threshold.
    logic [7:0] fsel, fv;
    logic       go_left;

    always_comb begin
        case (feat)
            2'd0:    fsel = f0;
            2'd1:    fsel = f1;
            2'd2:    fsel = f2;
            default: fsel = f3;
        endcase
        fv      = fsel >> (3'd7 - nb);
        go_left = (fv <= thr);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        addr_n  = node_addr;
        depth_n = depth;
        class_n = out_class;
        err_n   = out_err;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    addr_n  = ADDR_W'(ROOT_ADDR);
                    depth_n = '0;
                    state_n = WALK;
                end
            end
            WALK: begin
                if (is_leaf) begin
                    class_n = thr[CLASS_W-1:0];
                    err_n   = 1'b0;
                    state_n = DONE;
                end else if (depth == DEPTH_W'(MAX_DEPTH - 1)) begin
                    class_n = '0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    addr_n  = go_left ? left_child : right_child;
                    depth_n = depth + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            node_addr <= ADDR_W'(ROOT_ADDR);
            depth     <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
            f0        <= '0;
            f1        <= '0;
            f2        <= '0;
            f3        <= '0;
        end else begin
            state     <= state_n;
            node_addr <= addr_n;
            depth     <= depth_n;
            out_class <= class_n;
            out_err   <= err_n;
            if (load) begin
                f0 <= X0;
                f1 <= X1;
                f2 <= X2;
                f3 <= X3;
            end
        end
    end

endmodule

// File: tb/tb_dtree_walker_ctrl.sv
// Testbench for dtree_walker_ctrl: directed trees plus randomized ROMs and
// samples, checked against a behavioural tree-walk model.
module tb_dtree_walker_ctrl;

    localparam int ADDR_W    = 7;
    localparam int CLASS_W   = 2;
    localparam int MAX_DEPTH = 15;
    localparam int NODE_W    = 14 + 2*ADDR_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic [7:0]         X0, X1, X2, X3;
    logic [ADDR_W-1:0]  node_addr;
    logic [NODE_W-1:0]  node_data;
    logic               out_valid, out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_err, busy;

    logic [NODE_W-1:0]  rom [128];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign node_data = rom[node_addr];

    dtree_walker_ctrl #(
        .ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .ROOT_ADDR(0), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3),
        .node_addr(node_addr), .node_data(node_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] mk_int(input int f, input int n, input int t,
                                                 input int l, input int r);
        return {1'b0, f[1:0], n[2:0], t[7:0], l[6:0], r[6:0]};
    endfunction

    function automatic logic [NODE_W-1:0] mk_leaf(input int c);
        return {1'b1, 5'd0, c[7:0], 14'd0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = mk_leaf(0);
    endtask

    // Reference: walk the tree as an algorithm. Returns class, abort flag and
    // number of nodes visited (leaf or aborting node included).
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, output int cls, output int err, output int k);
        int x[4];
        int addr;
        logic [NODE_W-1:0] w;
        x = '{int'(a), int'(b), int'(c), int'(d)};
        addr = 0;
        k = 0;
        cls = 0;
        err = 0;
        for (int depth = 0; depth < MAX_DEPTH; depth++) begin
            int f, n, t, fv;
            w = rom[addr];
            k++;
            t = int'(w[21:14]);
            if (w[27]) begin
                cls = t % (1 << CLASS_W);
                err = 0;
                return;
            end
            if (depth == MAX_DEPTH - 1) begin
                cls = 0;
                err = 1;
                return;
            end
            f  = int'(w[26:25]);
            n  = int'(w[24:22]) + 1;
            fv = x[f] / (1 << (8 - n));
            addr = (fv <= t) ? int'(w[13:7]) : int'(w[6:0]);
        end
    endtask

    task automatic run_sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int stall, input string tag);
        int ecls, eerr, ek, n;
        bit seen;
        model(a, b, c, d, ecls, eerr, ek);
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 32'(in_ready), 1);
        X0 = a; X1 = b; X2 = c; X3 = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Inputs after the handshake must not influence the walk.
        X0 = 8'($urandom); X1 = 8'($urandom); X2 = 8'($urandom); X3 = 8'($urandom);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1;
            else begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, ":latency"}, 32'(n), 32'(ek + 1));
        check({tag, ":class"}, 32'(out_class), 32'(ecls));
        check({tag, ":err"}, 32'(out_err), 32'(eerr));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(out_valid), 1);
            check({tag, ":hold_class"}, 32'(out_class), 32'(ecls));
            check({tag, ":hold_err"}, 32'(out_err), 32'(eerr));
            check({tag, ":hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ":release_in_ready"}, 32'(in_ready), 1);
        check({tag, ":release_out_valid"}, 32'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        X0 = '0; X1 = '0; X2 = '0; X3 = '0;
        clear_rom();
        #12;
        check("rst:in_ready", 32'(in_ready), 1);
        check("rst:out_valid", 32'(out_valid), 0);
        check("rst:out_class", 32'(out_class), 0);
        check("rst:out_err", 32'(out_err), 0);
        check("rst:busy", 32'(busy), 0);
        check("rst:node_addr", 32'(node_addr), 0);
        @(negedge clk);
        rst = 1'b0;

        // Two-level tree on the top two bits of X0.
        rom[0] = mk_int(0, 1, 0, 1, 2);
        rom[1] = mk_leaf(2);
        rom[2] = mk_leaf(1);
        run_sample(8'h3F, 8'h00, 8'h00, 8'h00, 0, "t1_left");
        run_sample(8'h40, 8'h00, 8'h00, 8'h00, 2, "t1_right");

        // Root leaf: shortest walk.
        clear_rom();
        rom[0] = mk_leaf(3);
        run_sample(8'h12, 8'h34, 8'h56, 8'h78, 0, "root_leaf");

        // Self loop aborts on the depth limit.
        rom[0] = mk_int(2, 7, 8'h80, 0, 0);
        run_sample(8'hFF, 8'h00, 8'h00, 8'h00, 5, "self_loop");

        // Three-level tree on the top four bits of X1.
        clear_rom();
        rom[0] = mk_int(1, 3, 4, 1, 2);
        rom[1] = mk_int(1, 3, 2, 3, 4);
        rom[2] = mk_int(1, 3, 9, 5, 6);
        rom[3] = mk_leaf(0);
        rom[4] = mk_leaf(1);
        rom[5] = mk_leaf(2);
        rom[6] = mk_leaf(3);
        run_sample(8'h00, 8'h10, 8'h00, 8'h00, 0, "x1_10");
        run_sample(8'h00, 8'h30, 8'h00, 8'h00, 1, "x1_30");
        run_sample(8'h00, 8'h90, 8'h00, 8'h00, 0, "x1_90");
        run_sample(8'h00, 8'hF0, 8'h00, 8'h00, 3, "x1_f0");

        // Reset in the second WALK cycle discards the walk.
        rom[0] = mk_int(0, 7, 255, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst:in_ready", 32'(in_ready), 1);
        check("midrst:out_valid", 32'(out_valid), 0);
        check("midrst:node_addr", 32'(node_addr), 0);
        check("midrst:busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst:no_pulse", 32'(pulses), 0);
        rom[0] = mk_int(0, 1, 0, 1, 2);
        rom[1] = mk_leaf(2);
        rom[2] = mk_leaf(1);
        run_sample(8'hC0, 8'h00, 8'h00, 8'h00, 0, "post_rst");

        // Randomized ROMs and samples.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 128; i++) begin
                if ($urandom_range(0, 2) == 0)
                    rom[i] = mk_leaf(int'($urandom_range(0, 255)));
                else
                    rom[i] = mk_int(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                                    int'($urandom_range(0, 255)),
                                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            run_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 3)), $sformatf("rand%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
